// File: rtl/gtx_common_drp_arbiter.sv
// Round-robin arbiter sharing one GTXE2_COMMON DRP port between NUM_REQ requesters.
// One captured request per requester, one DRP access in flight, timeout reports an error.
module gtx_common_drp_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  DRPCLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    REQ_EN,
  input  logic [NUM_REQ-1:0]    REQ_WE,
  input  logic [8*NUM_REQ-1:0]  REQ_ADDR,
  input  logic [16*NUM_REQ-1:0] REQ_DI,
  output logic [NUM_REQ-1:0]    REQ_RDY,
  output logic [NUM_REQ-1:0]    REQ_ERR,
  output logic [15:0]           REQ_DO,
  output logic [NUM_REQ-1:0]    GRANT,
  output logic                  BUSY,
  output logic [7:0]            DRPADDR,
  output logic                  DRPEN,
  output logic                  DRPWE,
  output logic [15:0]           DRPDI,
  input  logic [15:0]           DRPDO,
  input  logic                  DRPRDY
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           gidx_q, gidx_d;
  logic [NUM_REQ-1:0]      pend_q, pend_d;
  logic [NUM_REQ-1:0]      swe_q, swe_d;
  logic [8*NUM_REQ-1:0]    saddr_q, saddr_d;
  logic [16*NUM_REQ-1:0]   sdi_q, sdi_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic [7:0]              daddr_q, daddr_d;
  logic                    den_q, den_d;
  logic                    dwe_q, dwe_d;
  logic [15:0]             ddi_q, ddi_d;
  logic [NUM_REQ-1:0]      rdy_q, rdy_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
  logic [15:0]             do_q, do_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    found;
  logic [PW-1:0]           sel;
  logic [PW-1:0]           idx;
  logic                    done;
  logic                    tout;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    pend_d  = pend_q;
    swe_d   = swe_q;
    saddr_d = saddr_q;
    sdi_d   = sdi_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    daddr_d = daddr_q;
    den_d   = 1'b0;
    dwe_d   = dwe_q;
    ddi_d   = ddi_q;
    rdy_d   = '0;
    err_d   = '0;
    do_d    = do_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    done    = 1'b0;
    tout    = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (REQ_EN[i] && !pend_q[i]) begin
        pend_d[i]          = 1'b1;
        swe_d[i]           = REQ_WE[i];
        saddr_d[8*i +: 8]  = REQ_ADDR[8*i +: 8];
        sdi_d[16*i +: 16]  = REQ_DI[16*i +: 16];
      end
    end

    // scan starts one past the last owner so every requester gets a turn
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d        = sel;
          gidx_d       = sel;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          busy_d       = 1'b1;
          den_d        = 1'b1;
          daddr_d      = saddr_q[8*sel +: 8];
          dwe_d        = swe_q[sel];
          ddi_d        = sdi_q[16*sel +: 16];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
        done    = DRPRDY;
      end
      WAIT: begin
        if (DRPRDY) begin
          done = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done || tout) begin
      rdy_d[gidx_q]  = 1'b1;
      err_d[gidx_q]  = tout;
      pend_d[gidx_q] = 1'b0;
      grant_d        = '0;
      busy_d         = 1'b0;
      state_d        = IDLE;
      if (tout) begin
        do_d = '0;
      end else if (!dwe_q) begin
        do_d = DRPDO;
      end
    end
  end

  always_ff @(posedge DRPCLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      gidx_q  <= '0;
      pend_q  <= '0;
      swe_q   <= '0;
      saddr_q <= '0;
      sdi_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      daddr_q <= '0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      ddi_q   <= '0;
      rdy_q   <= '0;
      err_q   <= '0;
      do_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      pend_q  <= pend_d;
      swe_q   <= swe_d;
      saddr_q <= saddr_d;
      sdi_q   <= sdi_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      daddr_q <= daddr_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      ddi_q   <= ddi_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      do_q    <= do_d;
      cnt_q   <= cnt_d;
    end
  end

  assign REQ_RDY = rdy_q;
  assign REQ_ERR = err_q;
  assign REQ_DO  = do_q;
  assign GRANT   = grant_q;
  assign BUSY    = busy_q;
  assign DRPADDR = daddr_q;
  assign DRPEN   = den_q;
  assign DRPWE   = dwe_q;
  assign DRPDI   = ddi_q;

endmodule

// File: tb/tb_gtx_common_drp_arbiter.sv
// Bench for gtx_common_drp_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_gtx_common_drp_arbiter;

  localparam int N  = 2;
  localparam int TO = 64;

  logic            DRPCLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    REQ_EN = '0;
  logic [N-1:0]    REQ_WE = '0;
  logic [8*N-1:0]  REQ_ADDR = '0;
  logic [16*N-1:0] REQ_DI = '0;
  logic [N-1:0]    REQ_RDY;
  logic [N-1:0]    REQ_ERR;
  logic [15:0]     REQ_DO;
  logic [N-1:0]    GRANT;
  logic            BUSY;
  logic [7:0]      DRPADDR;
  logic            DRPEN;
  logic            DRPWE;
  logic [15:0]     DRPDI;
  logic [15:0]     DRPDO = '0;
  logic            DRPRDY = 1'b0;

  gtx_common_drp_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .DRPCLK(DRPCLK),
    .RST(RST),
    .REQ_EN(REQ_EN),
    .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR),
    .REQ_DI(REQ_DI),
    .REQ_RDY(REQ_RDY),
    .REQ_ERR(REQ_ERR),
    .REQ_DO(REQ_DO),
    .GRANT(GRANT),
    .BUSY(BUSY),
    .DRPADDR(DRPADDR),
    .DRPEN(DRPEN),
    .DRPWE(DRPWE),
    .DRPDI(DRPDI),
    .DRPDO(DRPDO),
    .DRPRDY(DRPRDY)
  );

  always #5 DRPCLK = ~DRPCLK;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  bit rand_mode = 1'b0;
  bit quiet = 1'b0;
  int en_cnt = 0;
  int rdy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port and how many edges since grant.
  int          m_owner = -1;
  int          m_t = 0;
  int          m_ptr = N - 1;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_we = '0;
  logic [7:0]  m_addr [N];
  logic [15:0] m_di [N];
  logic [N-1:0] e_rdy = '0, e_err = '0, e_grant = '0;
  logic [15:0] e_do = '0, e_di = '0;
  logic [7:0]  e_addr = '0;
  logic        e_en = 1'b0, e_we = 1'b0, e_busy = 1'b0;

  task automatic model_step();
    logic [N-1:0] p_old;
    bit idle_old;
    int o;
    if (RST) begin
      m_owner = -1; m_t = 0; m_ptr = N - 1; m_pend = '0;
      e_rdy = '0; e_err = '0; e_grant = '0; e_do = '0; e_di = '0;
      e_addr = '0; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      return;
    end
    p_old = m_pend;
    idle_old = (m_owner < 0);
    e_rdy = '0; e_err = '0; e_en = 1'b0;
    if (!idle_old) begin
      m_t++;
      o = m_owner;
      if (DRPRDY || m_t == TO + 1) begin
        e_rdy[o] = 1'b1;
        if (!DRPRDY) begin
          e_err[o] = 1'b1;
          e_do = '0;
        end else if (!e_we) begin
          e_do = DRPDO;
        end
        m_pend[o] = 1'b0;
        m_owner = -1;
        e_grant = '0;
        e_busy = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (REQ_EN[i] && !p_old[i]) begin
        m_pend[i] = 1'b1;
        m_we[i]   = REQ_WE[i];
        m_addr[i] = REQ_ADDR[8*i +: 8];
        m_di[i]   = REQ_DI[16*i +: 16];
      end
    end
    if (idle_old) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_owner < 0 && p_old[j]) begin
          m_owner = j; m_ptr = j; m_t = 0;
          e_en = 1'b1; e_grant = '0; e_grant[j] = 1'b1; e_busy = 1'b1;
          e_addr = m_addr[j]; e_we = m_we[j]; e_di = m_di[j];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge DRPCLK or posedge RST);
    model_step();
  end

  initial forever begin
    @(negedge DRPCLK);
    if (!RST) begin
      if (DRPEN) en_cnt++;
      if (|REQ_RDY) rdy_cnt++;
    end
    if (cmp_on) begin
      chk("REQ_RDY", 32'(REQ_RDY), 32'(e_rdy));
      chk("REQ_ERR", 32'(REQ_ERR), 32'(e_err));
      chk("REQ_DO", 32'(REQ_DO), 32'(e_do));
      chk("GRANT", 32'(GRANT), 32'(e_grant));
      chk("BUSY", 32'(BUSY), 32'(e_busy));
      chk("DRPEN", 32'(DRPEN), 32'(e_en));
      chk("DRPADDR", 32'(DRPADDR), 32'(e_addr));
      chk("DRPWE", 32'(DRPWE), 32'(e_we));
      chk("DRPDI", 32'(DRPDI), 32'(e_di));
    end
  end

  task automatic tick();
    @(negedge DRPCLK);
    #1;
    REQ_EN = '0;
    DRPRDY = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom % 6 == 0) begin
          REQ_EN[i] = 1'b1;
          REQ_WE[i] = 1'($urandom % 2);
          REQ_ADDR[8*i +: 8] = 8'($urandom);
          REQ_DI[16*i +: 16] = 16'($urandom);
        end
      end
      DRPRDY = !quiet && ($urandom % 4 == 0);
      DRPDO = 16'($urandom);
    end
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    while (!DRPEN && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_drpen_seen"}, 32'(DRPEN), 32'd1);
  endtask

  int n, s, s2, issued;
  logic [N-1:0] g;

  initial begin
    repeat (3) tick();
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_drpen", 32'(DRPEN), 32'd0);
    chk("rst_rdy", 32'(REQ_RDY), 32'd0);
    chk("rst_do", 32'(REQ_DO), 32'd0);
    cmp_on = 1'b1;
    RST = 1'b0;
    tick();

    // read on requester 0
    REQ_WE[0] = 1'b0; REQ_ADDR[7:0] = 8'h5E; REQ_EN = 2'b01;
    tick();
    wait_en("t1");
    chk("t1_addr", 32'(DRPADDR), 32'h5E);
    chk("t1_we", 32'(DRPWE), 32'd0);
    chk("t1_grant", 32'(GRANT), 32'd1);
    tick(); tick();
    DRPRDY = 1'b1; DRPDO = 16'h1234;
    tick();
    chk("t1_rdy", 32'(REQ_RDY), 32'd1);
    chk("t1_do", 32'(REQ_DO), 32'h1234);
    chk("t1_err", 32'(REQ_ERR), 32'd0);
    tick();
    chk("t1_pulse", 32'(REQ_RDY), 32'd0);

    // write on requester 1
    REQ_WE[1] = 1'b1; REQ_ADDR[15:8] = 8'h88; REQ_DI[31:16] = 16'hA5A5;
    REQ_EN = 2'b10;
    tick();
    wait_en("t2");
    chk("t2_addr", 32'(DRPADDR), 32'h88);
    chk("t2_we", 32'(DRPWE), 32'd1);
    chk("t2_di", 32'(DRPDI), 32'hA5A5);
    tick();
    chk("t2_en_one_cycle", 32'(DRPEN), 32'd0);
    DRPRDY = 1'b1; DRPDO = 16'hBEEF;
    tick();
    chk("t2_rdy", 32'(REQ_RDY), 32'd2);
    chk("t2_do_kept", 32'(REQ_DO), 32'h1234);

    // fairness after reset
    RST = 1'b1; tick(); RST = 1'b0; tick();
    REQ_WE = '0; REQ_EN = 2'b11; issued = 2;
    tick();
    for (int a = 0; a < 8; a++) begin
      wait_en("t3");
      chk("t3_grant", 32'(GRANT), 32'(1 << (a % 2)));
      g = GRANT;
      DRPRDY = 1'b1;
      tick();
      chk("t3_rdy", 32'(REQ_RDY), 32'(g));
      if (issued < 8) begin
        REQ_EN = g;
        issued++;
      end
    end
    tick();

    // reset while waiting for DRPRDY
    REQ_EN = 2'b01; REQ_ADDR[7:0] = 8'h21;
    tick();
    wait_en("t5");
    tick(); tick();
    RST = 1'b1;
    #1;
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_grant", 32'(GRANT), 32'd0);
    chk("t5_do", 32'(REQ_DO), 32'd0);
    chk("t5_addr", 32'(DRPADDR), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    DRPRDY = 1'b1; s = rdy_cnt;
    tick(); tick(); tick();
    chk("t5_late_rdy", 32'(rdy_cnt - s), 32'd0);
    REQ_EN = 2'b01;
    tick();
    wait_en("t5b");
    DRPRDY = 1'b1; DRPDO = 16'h0F0F;
    tick();
    chk("t5b_rdy", 32'(REQ_RDY), 32'd1);
    chk("t5b_do", 32'(REQ_DO), 32'h0F0F);

    // timeout
    REQ_EN = 2'b01;
    tick();
    wait_en("t4");
    n = 0;
    tick(); n++;
    while (!(|REQ_RDY) && n < 100) begin
      tick(); n++;
    end
    chk("t4_latency", 32'(n), 32'd65);
    chk("t4_err", 32'(REQ_ERR), 32'd1);
    chk("t4_do", 32'(REQ_DO), 32'd0);
    repeat (4) tick();
    DRPRDY = 1'b1; s = rdy_cnt;
    tick(); tick(); tick();
    chk("t4_spurious", 32'(rdy_cnt - s), 32'd0);

    // duplicate strobes while in flight
    s = en_cnt; s2 = rdy_cnt;
    REQ_EN = 2'b01; tick();
    REQ_EN = 2'b01; tick();
    REQ_EN = 2'b01; tick();
    REQ_EN = 2'b01; tick();
    DRPRDY = 1'b1;
    repeat (10) tick();
    chk("t6_drpen_count", 32'(en_cnt - s), 32'd1);
    chk("t6_rdy_count", 32'(rdy_cnt - s2), 32'd1);

    // randomized traffic
    rand_mode = 1'b1;
    for (int blk = 0; blk < 12; blk++) begin
      quiet = ($urandom % 3 == 0);
      if (blk == 5) begin
        RST = 1'b1; tick(); RST = 1'b0;
      end
      repeat (250) tick();
    end
    rand_mode = 1'b0;
    repeat (100) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
